// File: rtl/div_req_scheduler_if.sv
// Signal bundle between div_req_scheduler, its requesters, the shared divider core and the response sink.
// master = the scheduler's view; slave = the surrounding environment's view.
interface div_req_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*WIDTH-1:0]   req_dividend;
    logic [N_REQ*WIDTH-1:0]   req_divisor;
    logic                     div_start;
    logic [WIDTH-1:0]         div_dividend;
    logic [WIDTH-1:0]         div_divisor;
    logic                     div_done;
    logic [WIDTH-1:0]         div_quotient;
    logic [WIDTH-1:0]         div_remainder;
    logic                     resp_valid;
    logic [$clog2(N_REQ)-1:0] resp_id;
    logic [WIDTH-1:0]         resp_quotient;
    logic [WIDTH-1:0]         resp_remainder;
    logic                     resp_dbz;
    logic                     resp_err;
    logic                     busy;

    modport master (
        input  req_valid, req_dividend, req_divisor, div_done, div_quotient, div_remainder,
        output req_ready, div_start, div_dividend, div_divisor,
        output resp_valid, resp_id, resp_quotient, resp_remainder, resp_dbz, resp_err, busy
    );

    modport slave (
        output req_valid, req_dividend, req_divisor, div_done, div_quotient, div_remainder,
        input  req_ready, div_start, div_dividend, div_divisor,
        input  resp_valid, resp_id, resp_quotient, resp_remainder, resp_dbz, resp_err, busy
    );
endinterface

// File: rtl/div_req_scheduler.sv
// Round-robin scheduler sharing one start/done divider core among N_REQ requesters,
// with local divide-by-zero handling and a WAIT watchdog.
module div_req_scheduler #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    div_req_scheduler_if.master bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int TW  = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             err_q, err_d;

    logic             grant_any;
    logic [IDW-1:0]   grant_id;
    logic [WIDTH-1:0] grant_dividend;
    logic [WIDTH-1:0] grant_divisor;
    logic             accept;
    logic [N_REQ-1:0] ready_vec;
    int               best_dist;

    // Winner is the valid requester at the smallest circular distance above the pointer.
    always_comb begin
        grant_any      = 1'b0;
        grant_id       = '0;
        grant_dividend = '0;
        grant_divisor  = '0;
        best_dist      = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req_valid[i] && ((i + N_REQ - int'(rr_q)) % N_REQ) < best_dist) begin
                best_dist      = (i + N_REQ - int'(rr_q)) % N_REQ;
                grant_any      = 1'b1;
                grant_id       = IDW'(i);
                grant_dividend = bus.req_dividend[i*WIDTH +: WIDTH];
                grant_divisor  = bus.req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    assign accept = (state_q == S_IDLE) && grant_any && !rst;

    always_comb begin
        ready_vec = '0;
        if (accept) begin
            ready_vec[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        timer_d    = timer_q;
        owner_d    = owner_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    owner_d    = grant_id;
                    dividend_d = grant_dividend;
                    divisor_d  = grant_divisor;
                    rr_d       = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
                    if (grant_divisor == '0) begin
                        // Divide-by-zero never reaches the core.
                        state_d = S_RESP;
                        quot_d  = '1;
                        rem_d   = grant_dividend;
                        dbz_d   = 1'b1;
                        err_d   = 1'b0;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                timer_d = '0;
            end
            S_WAIT: begin
                // A completion in the last watchdog cycle still counts as success.
                if (bus.div_done) begin
                    state_d = S_RESP;
                    quot_d  = bus.div_quotient;
                    rem_d   = bus.div_remainder;
                    dbz_d   = 1'b0;
                    err_d   = 1'b0;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_RESP;
                    quot_d  = '0;
                    rem_d   = '0;
                    dbz_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            timer_q <= timer_d;
        end
    end

    // Job payload needs no reset: every output using it is gated by state.
    always_ff @(posedge clk) begin
        owner_q    <= owner_d;
        dividend_q <= dividend_d;
        divisor_q  <= divisor_d;
        quot_q     <= quot_d;
        rem_q      <= rem_d;
        dbz_q      <= dbz_d;
        err_q      <= err_d;
    end

    assign bus.req_ready      = ready_vec;
    assign bus.div_start      = (state_q == S_ISSUE);
    assign bus.div_dividend   = (state_q != S_IDLE) ? dividend_q : '0;
    assign bus.div_divisor    = (state_q != S_IDLE) ? divisor_q : '0;
    assign bus.resp_valid     = (state_q == S_RESP);
    assign bus.resp_id        = (state_q == S_RESP) ? owner_q : '0;
    assign bus.resp_quotient  = (state_q == S_RESP) ? quot_q : '0;
    assign bus.resp_remainder = (state_q == S_RESP) ? rem_q : '0;
    assign bus.resp_dbz       = (state_q == S_RESP) && dbz_q;
    assign bus.resp_err       = (state_q == S_RESP) && err_q;
    assign bus.busy           = (state_q != S_IDLE);
endmodule

// File: tb/tb_div_req_scheduler.sv
// Randomized and directed bench for div_req_scheduler, checked every cycle against a job-level model.
module tb_div_req_scheduler;
    localparam int N   = 4;
    localparam int W   = 4;
    localparam int TO  = 16;
    localparam int IDW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;

    div_req_scheduler_if #(.N_REQ(N), .WIDTH(W)) bus ();

    div_req_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ideal divider core with programmable latency (0 = never completes).
    int              core_lat = 1;
    bit              core_rand = 1'b0;
    int              core_cnt = 0;
    logic [W-1:0]    core_q, core_r;
    bit              stale_pulse = 1'b0;

    initial forever begin
        @(negedge clk);
        if (bus.div_start === 1'b1 && !rst) begin
            core_cnt = core_rand ? (($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6))) : core_lat;
            core_q   = (bus.div_divisor != 0) ? bus.div_dividend / bus.div_divisor : '1;
            core_r   = (bus.div_divisor != 0) ? bus.div_dividend % bus.div_divisor : bus.div_dividend;
        end
    end

    initial begin
        bus.div_done      = 1'b0;
        bus.div_quotient  = '0;
        bus.div_remainder = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.div_done      = 1'b0;
            bus.div_quotient  = '0;
            bus.div_remainder = '0;
            if (stale_pulse) begin
                stale_pulse       = 1'b0;
                bus.div_done      = 1'b1;
                bus.div_quotient  = 4'd7;
                bus.div_remainder = 4'd7;
            end else if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    bus.div_done      = 1'b1;
                    bus.div_quotient  = core_q;
                    bus.div_remainder = core_r;
                end
            end
        end
    end

    // Job-level reference model.
    bit           m_job = 1'b0;
    int           m_ptr = 0;
    int           m_t, m_owner, m_resp_at;
    logic [W-1:0] m_a, m_b, m_q, m_r;
    logic         m_dbz, m_err;

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Monitor records for directed checks.
    logic [N-1:0]   acc_seen = '0;
    int             grants[$];
    int             start_cnt = 0, resp_cnt = 0;
    int             last_acc_cyc, last_acc_id, last_start_cyc, last_resp_cyc;
    logic [IDW-1:0] r_id;
    logic [W-1:0]   r_q, r_r;
    logic           r_dbz, r_err, r_busy;

    logic [N-1:0]   e_ready;
    logic           e_start, e_busy, e_valid, e_dbz, e_err;
    logic [IDW-1:0] e_id;
    logic [W-1:0]   e_q, e_r;
    int             w;

    initial forever begin
        @(negedge clk);
        if (started && !rst) begin
            e_ready = '0; e_start = 1'b0; e_busy = 1'b0; e_valid = 1'b0;
            e_id = '0; e_q = '0; e_r = '0; e_dbz = 1'b0; e_err = 1'b0;
            if (!m_job) begin
                w = rr_pick(bus.req_valid, m_ptr);
                if (w >= 0) e_ready[w] = 1'b1;
            end else begin
                e_busy  = 1'b1;
                e_start = (m_b != 0) && (cyc == m_t + 1);
                if (cyc == m_resp_at) begin
                    e_valid = 1'b1;
                    e_id    = IDW'(m_owner);
                    e_q     = m_q;
                    e_r     = m_r;
                    e_dbz   = m_dbz;
                    e_err   = m_err;
                end
            end
            chk("cycle_outputs",
                64'({bus.req_ready, bus.div_start, bus.busy, bus.resp_valid, bus.resp_id,
                     bus.resp_quotient, bus.resp_remainder, bus.resp_dbz, bus.resp_err}),
                64'({e_ready, e_start, e_busy, e_valid, e_id, e_q, e_r, e_dbz, e_err}));
            if (e_start) begin
                chk("core_operands", 64'({bus.div_dividend, bus.div_divisor}), 64'({m_a, m_b}));
            end
        end
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_ready[i]) begin
                    acc_seen[i]  = 1'b1;
                    last_acc_cyc = cyc;
                    last_acc_id  = i;
                    grants.push_back(i);
                end
            end
            if (bus.div_start) begin
                start_cnt++;
                last_start_cyc = cyc;
            end
            if (bus.resp_valid) begin
                resp_cnt++;
                last_resp_cyc = cyc;
                r_id   = bus.resp_id;
                r_q    = bus.resp_quotient;
                r_r    = bus.resp_remainder;
                r_dbz  = bus.resp_dbz;
                r_err  = bus.resp_err;
                r_busy = bus.busy;
            end
        end
        if (rst) begin
            m_job = 1'b0;
            m_ptr = 0;
        end else if (!m_job) begin
            w = rr_pick(bus.req_valid, m_ptr);
            if (w >= 0) begin
                m_job   = 1'b1;
                m_t     = cyc;
                m_owner = w;
                m_a     = bus.req_dividend[w*W +: W];
                m_b     = bus.req_divisor[w*W +: W];
                m_ptr   = (w + 1) % N;
                if (m_b == 0) begin
                    m_resp_at = cyc + 1;
                    m_q = '1; m_r = m_a; m_dbz = 1'b1; m_err = 1'b0;
                end else begin
                    m_resp_at = -1;
                end
            end
        end else if (cyc == m_resp_at) begin
            m_job = 1'b0;
        end else if (m_resp_at < 0 && cyc >= m_t + 2) begin
            if (bus.div_done) begin
                m_resp_at = cyc + 1;
                m_q = m_a / m_b; m_r = m_a % m_b; m_dbz = 1'b0; m_err = 1'b0;
            end else if (cyc == m_t + 1 + TO) begin
                m_resp_at = cyc + 1;
                m_q = '0; m_r = '0; m_dbz = 1'b0; m_err = 1'b1;
            end
        end
    end

    // Requester behaviour: 0 = directed, 1 = re-request forever, 2 = random.
    int mode = 0;

    task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_valid[i]            = 1'b1;
        bus.req_dividend[i*W +: W]  = a;
        bus.req_divisor[i*W +: W]   = b;
    endtask

    task automatic raise(input int i, input bit nonzero);
        logic [W-1:0] a, b;
        a = W'($urandom);
        b = W'($urandom);
        if (nonzero && b == 0) b = 1;
        if (!nonzero && $urandom_range(0, 7) == 0) b = 0;
        send(i, a, b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_seen[i]) begin
                acc_seen[i]      = 1'b0;
                bus.req_valid[i] = 1'b0;
                if (mode == 1) raise(i, 1'b1);
            end
            if (mode == 2 && !bus.req_valid[i] && $urandom_range(0, 2) == 0) raise(i, 1'b0);
        end
    endtask

    task automatic wait_resp(input int base, input int budget, input string name);
        int n = 0;
        while (resp_cnt == base && n < budget) begin
            step();
            n++;
        end
        chk({name, "_arrived"}, 64'(resp_cnt != base), 64'd1);
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while ((bus.req_valid != '0 || bus.busy) && n < budget) begin
            step();
            n++;
        end
        chk({name, "_drained"}, 64'(bus.req_valid == '0 && !bus.busy), 64'd1);
    endtask

    int base, sc;
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b0;
        started = 1'b1;
        chk("reset_outputs",
            64'({bus.req_ready, bus.div_start, bus.div_dividend, bus.div_divisor, bus.resp_valid,
                 bus.resp_id, bus.resp_quotient, bus.resp_remainder, bus.resp_dbz, bus.resp_err, bus.busy}),
            64'd0);

        // 10/3 with a 4-cycle core
        core_lat = 4;
        base = resp_cnt;
        send(0, 4'd10, 4'd3);
        wait_resp(base, 40, "t1");
        chk("t1_acc_id", 64'(last_acc_id), 64'd0);
        chk("t1_start_lat", 64'(last_start_cyc - last_acc_cyc), 64'd1);
        chk("t1_resp_lat", 64'(last_resp_cyc - last_acc_cyc), 64'd6);
        chk("t1_resp", 64'({r_id, r_q, r_r, r_dbz, r_err}), 64'({2'd0, 4'd3, 4'd1, 1'b0, 1'b0}));

        // 7/0 answered locally
        sc   = start_cnt;
        base = resp_cnt;
        send(2, 4'd7, 4'd0);
        wait_resp(base, 10, "t2");
        chk("t2_resp_lat", 64'(last_resp_cyc - last_acc_cyc), 64'd1);
        chk("t2_resp", 64'({r_id, r_q, r_r, r_dbz, r_err}), 64'({2'd2, 4'hF, 4'd7, 1'b1, 1'b0}));
        chk("t2_no_start", 64'(start_cnt - sc), 64'd0);

        // Continuous contention right after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        grants.delete();
        core_lat = 1;
        mode = 1;
        for (int i = 0; i < N; i++) raise(i, 1'b1);
        for (int n = 0; n < 80 && grants.size() < 6; n++) step();
        chk("t3_grant_count", 64'(grants.size() >= 6), 64'd1);
        for (int k = 0; k < 6; k++) begin
            if (k < grants.size()) chk("t3_grant_order", 64'(grants[k]), 64'(exp_order[k]));
        end
        mode = 0;
        drain(80, "t3");

        // Core never answers: watchdog
        core_lat = 0;
        base = resp_cnt;
        send(1, 4'd5, 4'd1);
        wait_resp(base, 40, "t4");
        chk("t4_resp_lat", 64'(last_resp_cyc - last_acc_cyc), 64'd18);
        chk("t4_resp", 64'({r_id, r_q, r_r, r_dbz, r_err}), 64'({2'd1, 4'd0, 4'd0, 1'b0, 1'b1}));
        chk("t4_busy_at_resp", 64'(r_busy), 64'd1);
        chk("t4_busy_after", 64'(bus.busy), 64'd0);

        // Completion in the last watchdog cycle
        core_lat = 16;
        base = resp_cnt;
        send(0, 4'd4, 4'd2);
        wait_resp(base, 40, "t5");
        chk("t5_resp_lat", 64'(last_resp_cyc - last_acc_cyc), 64'd18);
        chk("t5_resp", 64'({r_id, r_q, r_r, r_dbz, r_err}), 64'({2'd0, 4'd2, 4'd0, 1'b0, 1'b0}));

        // Reset while waiting, stale done, then a fresh job
        core_lat = 0;
        send(1, 4'd3, 4'd1);
        repeat (5) step();
        chk("t6_busy_before_rst", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_outputs_after_rst",
            64'({bus.req_ready, bus.div_start, bus.div_dividend, bus.div_divisor, bus.resp_valid,
                 bus.resp_id, bus.resp_quotient, bus.resp_remainder, bus.resp_dbz, bus.resp_err, bus.busy}),
            64'd0);
        base = resp_cnt;
        stale_pulse = 1'b1;
        repeat (3) step();
        chk("t6_stale_done_ignored", 64'(resp_cnt - base), 64'd0);
        core_lat = 3;
        base = resp_cnt;
        send(3, 4'd9, 4'd2);
        wait_resp(base, 20, "t6");
        chk("t6_resp", 64'({r_id, r_q, r_r, r_dbz, r_err}), 64'({2'd3, 4'd4, 4'd1, 1'b0, 1'b0}));

        // Random traffic against the model
        base = resp_cnt;
        core_rand = 1'b1;
        mode = 2;
        repeat (3000) step();
        mode = 0;
        drain(200, "rand");
        core_rand = 1'b0;
        chk("rand_activity", 64'((resp_cnt - base) > 50), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_req_scheduler.md
Name: div_req_scheduler

Overview:
- Shares one multi-cycle binary divider core (start/done interface) among N_REQ requesters.
- Round-robin arbitration; latches the winner's operands and sequences the divider with start/done.
- Handles divide-by-zero locally without invoking the core; applies a watchdog timeout.
- Returns quotient/remainder tagged with the requester ID. Sits between client blocks and the divider datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 4, operand/result width in bits.
- TIMEOUT, 16, maximum cycles spent in WAIT before an error response (>=2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_dividend  in  N_REQ*WIDTH  packed; requester i uses bits [i*WIDTH +: WIDTH].
- req_divisor  in  N_REQ*WIDTH  packed, same slicing.
- div_start  out  1  one-cycle start pulse to the divider core.
- div_dividend  out  WIDTH  latched operand to the core.
- div_divisor  out  WIDTH  latched operand to the core.
- div_done  in  1  core completion pulse; results valid in the same cycle.
- div_quotient  in  WIDTH  core quotient.
- div_remainder  in  WIDTH  core remainder.
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_id  out  $clog2(N_REQ)  requester the response belongs to.
- resp_quotient  out  WIDTH  quotient.
- resp_remainder  out  WIDTH  remainder.
- resp_dbz  out  1  divide-by-zero flag.
- resp_err  out  1  timeout flag.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, rr pointer=0, timer=0.
  - All outputs 0, including div_dividend and div_divisor.
  - Reset mid-operation abandons the job: no response is issued, and any later div_done is ignored.
- States: IDLE, ISSUE, WAIT, RESP. State is registered; the outputs below are either registered or decoded from registered state.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from pointer upward with wrap.
  - req_ready[winner]=1 combinationally in this cycle only. The handshake completes in that cycle.
  - req_ready is 0 in all other states.
  - On acceptance: latch operands and owner ID, then set pointer=(winner+1) mod N_REQ.
  - Next state: if divisor==0, go to RESP with dbz. Otherwise go to ISSUE.
- ISSUE:
  - div_start=1 for exactly this cycle.
  - div_dividend/div_divisor hold the latched values from ISSUE until the return to IDLE.
  - Next state WAIT, timer=0.
- WAIT:
  - div_done=1: capture div_quotient/div_remainder, go to RESP.
  - Else if timer==TIMEOUT-1: go to RESP with err (quotient=0, remainder=0).
  - Else timer++.
  - If div_done and timeout coincide, done wins (err=0).
  - div_done in any state other than WAIT is ignored.
- RESP:
  - resp_valid=1 for one cycle with resp_id=owner.
  - Normal completion: results from the core, dbz=0, err=0.
  - Divide-by-zero: quotient={WIDTH{1'b1}}, remainder=latched dividend, dbz=1, err=0.
  - Timeout: q=r=0, err=1, dbz=0.
  - Next state IDLE.
  - resp_* fields are 0 whenever resp_valid=0.
- Latency, with acceptance in cycle T:
  - div_start in T+1.
  - If div_done arrives in cycle D, resp_valid is in D+1.
  - Divide-by-zero: resp_valid in T+1.
  - Timeout: resp_valid in T+2+TIMEOUT.
  - Earliest next acceptance is the cycle after RESP.
- Requests not granted stay pending; requesters must hold valid and operands stable until accepted.
- Fairness: a continuously valid requester waits at most N_REQ-1 other jobs.

Test Plan:
- Single request, divider model done 4 cycles after start: req 0 sends 10/3 -> req_ready[0] at T, div_start at T+1, resp_valid at T+6 with id=0, q=3, r=1, dbz=0, err=0.
- Divide-by-zero: req 2 sends 7/0 -> resp_valid at T+1, id=2, q=4'hF, r=7, dbz=1; div_start never asserted.
- All four requesters hold valid continuously, each job taking 3 cycles -> grant order 0,1,2,3,0,1 and no requester granted twice before the others; after reset the first grant goes to 0.
- Divider model never asserts done, TIMEOUT=16 -> resp_valid exactly 18 cycles after acceptance with err=1, q=0, r=0; busy falls the next cycle.
- div_done asserted in the final WAIT cycle (timer==15) with q=2, r=0 -> err=0, q=2, r=0 returned.
- rst asserted during WAIT -> next cycle all outputs 0 and busy=0; a stale div_done is ignored. Then req 3 alone sends 9/2 -> granted, q=4, r=1.
